// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the core's memory-access stage. It accepts one
// load or store per request handshake and waits WAIT_CYCLES extra cycles.
// The access then happens on the edge that enters RESP. The response is held
// on a valid/ready channel until the initiator takes it.
//
// Configuration macro: DMEM_ERR_EN
//   defined   : rsp_err flags out-of-range, illegal funct3 and misaligned
//               accesses. Faulting stores do not write and faulting loads
//               return 0.
//   undefined : rsp_err is tied to 0. Misaligned addresses are rounded down
//               to the access size.
//
// Ports
//   clk, rst           clock (rising edge), async active-high reset
//   req_valid/ready    request handshake (req_ready = state is IDLE)
//   req_we             1 = store, 0 = load
//   req_addr           byte address
//   req_wdata          right-aligned store data
//   req_func3          RV32 funct3 size/sign code
//   rsp_valid/ready    response handshake
//   rsp_rdata          extended load data, 0 for stores
//   rsp_err            access fault
//
// State table
//   S_IDLE | waiting for a request, req_ready = 1
//   S_WAIT | counting wait states before the access
//   S_RESP | response held until rsp_ready
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam int          CW       = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
  localparam logic [31:0] BYTES    = 32'(DEPTH_WORDS * 4);
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr, r_wdata;
  logic [2:0]    r_func3;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept, w_rsp_done, w_enter_resp;
  logic          w_we;
  logic [31:0]   w_addr, w_wdata, w_off;
  logic [2:0]    w_func3;
  logic          w_in_range, w_legal, w_fault;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_rep, w_word, w_load;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  assign req_ready  = (r_state == S_IDLE);
  assign w_accept   = req_valid && req_ready;
  assign w_rsp_done = r_rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (WAIT_CYCLES == 0) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: if (r_cnt == '0) begin
        w_state_nxt  = S_RESP;
        w_enter_resp = 1'b1;
      end
      S_RESP: if (w_rsp_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, before the
  // latches hold the request, so in IDLE the live request fields are used.
  assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_func3 = (r_state == S_IDLE) ? req_func3 : r_func3;

  assign w_off      = w_addr - ADDR_BASE;
  assign w_in_range = (w_off < BYTES);
  assign w_idx      = w_off[AW+1:2];
  assign w_lane     = w_off[1:0];
  assign w_legal    = (w_func3 == 3'b000) || (w_func3 == 3'b001) || (w_func3 == 3'b010) ||
                      (w_func3 == 3'b100) || (w_func3 == 3'b101);

`ifdef DMEM_ERR_EN
  logic w_misaligned;
  assign w_misaligned = ((w_func3[1:0] == 2'b01) && w_off[0]) ||
                        ((w_func3 == 3'b010) && (w_off[1:0] != 2'b00));
  assign w_fault = !w_in_range || !w_legal || w_misaligned;
`else
  assign w_fault = !w_in_range || !w_legal;
`endif

  // Halfword enables ignore off[0], so misaligned halves round down naturally.
  always_comb begin
    w_be        = 4'b0000;
    w_wdata_rep = w_wdata;
    case (w_func3[1:0])
      2'b00: begin
        w_be        = 4'b0001 << w_lane;
        w_wdata_rep = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{w_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_word[{w_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load = '0;
    case (w_func3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = '0;
    endcase
    if (w_fault) w_load = '0;
  end

  // Storage is not reset. A reset stops the write even with zero wait states.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_we && !w_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_func3     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_func3 <= req_func3;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt   <= r_cnt - 1'b1;
      end
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_we ? 32'h0 : w_load;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

`ifdef DMEM_ERR_EN
  logic r_rsp_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_rsp_err <= 1'b0;
    else if (w_enter_resp) r_rsp_err <= w_fault;
    else if (w_rsp_done)   r_rsp_err <= 1'b0;
  end
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned WAITC = 1;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(WAITC),
    .ADDR_BASE(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // One complete transaction: the expectation is queued at accept and
  // checked against the response when it appears.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, input logic [31:0] erd, input logic eerr,
                      input string name);
    exp_t e;
    int   lat;
    bit   got;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s req_ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_func3 = f3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    e.rdata = erd; e.err = eerr;
    sb_q.push_back(e);
    lat = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid === 1'b1) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s timeout: rsp_valid never rose", name);
      void'(sb_q.pop_front());
      return;
    end
    total++;
    if (lat !== WAITC + 1) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, WAITC + 1);
    end
    e = sb_q.pop_front();
    total++;
    if (rsp_rdata !== e.rdata) begin
      bad++;
      $display("FAIL %s rdata: got %h want %h", name, rsp_rdata, e.rdata);
    end
    total++;
    if (rsp_err !== e.err) begin
      bad++;
      $display("FAIL %s err: got %b want %b", name, rsp_err, e.err);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({rsp_valid, req_ready, rsp_rdata, rsp_err} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL %s release: got v=%b rdy=%b d=%h e=%b want v=0 rdy=1 d=0 e=0",
               name, rsp_valid, req_ready, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_func3 = '0; rsp_ready = 1'b0;
    #12;
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b v=%b d=%h e=%b want rdy=1 v=0 d=0 e=0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word();
    xact(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, "sw_10");
    xact(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, "lw_10");
  endtask

  task automatic test_byte();
    xact(1'b1, 32'h20, 32'h11223344, 3'b010, 32'h0, 1'b0, "sw_20");
    xact(1'b1, 32'h21, 32'h00000080, 3'b000, 32'h0, 1'b0, "sb_21");
    xact(1'b0, 32'h20, 32'h0, 3'b010, 32'h11228044, 1'b0, "lw_20");
    xact(1'b0, 32'h21, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, "lb_21");
    xact(1'b0, 32'h21, 32'h0, 3'b100, 32'h00000080, 1'b0, "lbu_21");
    xact(1'b0, 32'h23, 32'h0, 3'b000, 32'h00000011, 1'b0, "lb_23");
  endtask

  task automatic test_half();
    xact(1'b1, 32'h30, 32'h0, 3'b010, 32'h0, 1'b0, "sw_30");
    xact(1'b1, 32'h32, 32'h0000ABCD, 3'b001, 32'h0, 1'b0, "sh_32");
    xact(1'b0, 32'h30, 32'h0, 3'b010, 32'hABCD0000, 1'b0, "lw_30");
    xact(1'b0, 32'h32, 32'h0, 3'b001, 32'hFFFFABCD, 1'b0, "lh_32");
    xact(1'b0, 32'h32, 32'h0, 3'b101, 32'h0000ABCD, 1'b0, "lhu_32");
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   got;
    bit   stray;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_func3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    e.rdata = 32'hDEADBEEF; e.err = 1'b0;
    sb_q.push_back(e);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL bp timeout: rsp_valid never rose");
    end
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({rsp_valid, req_ready, rsp_rdata} !== {1'b1, 1'b0, e.rdata}) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b rdy=%b d=%h want v=1 rdy=0 d=%h",
                 i, rsp_valid, req_ready, rsp_rdata, e.rdata);
      end
      if (i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
        req_func3 = 3'b010;
      end
      if (i == 2) req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
    end
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stray = 1;
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL bp_ignored_req: got stray response want none");
    end
    xact(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, "bp_lw_after");
  endtask

  task automatic test_misaligned();
    xact(1'b1, 32'h04, 32'h55667788, 3'b010, 32'h0, 1'b0, "sw_04");
    if (ERR_EN) begin
      xact(1'b0, 32'h06, 32'h0, 3'b010, 32'h0, 1'b1, "lw_06_mis");
      xact(1'b0, 32'h33, 32'h0, 3'b001, 32'h0, 1'b1, "lh_33_mis");
    end else begin
      xact(1'b0, 32'h06, 32'h0, 3'b010, 32'h55667788, 1'b0, "lw_06_mis");
      xact(1'b0, 32'h33, 32'h0, 3'b001, 32'hFFFFABCD, 1'b0, "lh_33_mis");
    end
  endtask

  task automatic test_range_illegal();
    xact(1'b1, 32'hFFC, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, "sw_last");
    xact(1'b0, 32'hFFC, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, "lw_last");
    xact(1'b0, 32'h1000, 32'h0, 3'b010, 32'h0, ERR_EN, "lw_oor");
    xact(1'b1, 32'h1010, 32'h12345678, 3'b010, 32'h0, ERR_EN, "sw_oor");
    xact(1'b1, 32'h10, 32'h0, 3'b111, 32'h0, ERR_EN, "s_illegal");
    xact(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, ERR_EN, "l_illegal");
    xact(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, "lw_10_intact");
  endtask

  task automatic test_reset_mid();
    xact(1'b1, 32'h40, 32'h0, 3'b010, 32'h0, 1'b0, "sw_40_zero");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF;
    req_func3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid: got rdy=%b v=%b d=%h e=%b want rdy=1 v=0 d=0 e=0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rst = 1'b0;
    xact(1'b0, 32'h40, 32'h0, 3'b010, 32'h0, 1'b0, "lw_40_after_rst");
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_backpressure();
    test_misaligned();
    test_range_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
